// File: rtl/lsu_pkg.sv
// Shared op encodings, FSM state type and op decode helpers for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} state_t;

  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] op_base_mask(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  // Stores only support the signed encodings; loads reject 011 and 11x.
  function automatic logic op_illegal(input logic we, input logic [2:0] op);
    if (we)
      return op[2] | (op[1:0] == 2'b11);
    else
      return (op == 3'b011) | (op == 3'b110) | (op == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/mask placement for either beat, and load merge plus sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [1:0]            off,
  input  logic                  st_beat1,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [3:0]            st_mask,
  input  logic                  ld_beat1,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic [DATA_WIDTH-1:0] ld_beat0,
  output logic [DATA_WIDTH-1:0] ld_merged,
  output logic [DATA_WIDTH-1:0] ld_result
);

  logic [3:0] base;
  logic [2:0] rem;
  logic [5:0] sh_lo;
  logic [5:0] sh_hi;

  // The second beat carries the bytes that spilled past the word boundary.
  always_comb begin
    base  = op_base_mask(op);
    rem   = 3'd4 - {1'b0, off};
    sh_lo = {1'b0, off, 3'b000};
    sh_hi = {rem, 3'b000};

    if (st_beat1) begin
      st_data = st_wdata >> sh_hi;
      st_mask = base >> rem;
    end else begin
      st_data = st_wdata << sh_lo;
      st_mask = base << off;
    end

    if (ld_beat1)
      ld_merged = ld_beat0 | (ld_rdata << sh_hi);
    else
      ld_merged = ld_rdata >> sh_lo;

    case (op)
      OP_B:    ld_result = {{(DATA_WIDTH-8){ld_merged[7]}}, ld_merged[7:0]};
      OP_H:    ld_result = {{(DATA_WIDTH-16){ld_merged[15]}}, ld_merged[15:0]};
      OP_BU:   ld_result = {{(DATA_WIDTH-8){1'b0}}, ld_merged[7:0]};
      OP_HU:   ld_result = {{(DATA_WIDTH-16){1'b0}}, ld_merged[15:0]};
      default: ld_result = ld_merged;
    endcase
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer between MEM stage and single-port data memory.
// Define LSU_MISALIGNED_SPLIT_EN to service misaligned accesses (split across two beats when crossing).
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state, state_d;
  logic                  we_q, we_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic                  cross_q, cross_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] beat0_q, beat0_d;

  logic                  mem_valid_d, mem_we_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, rsp_rdata_d;
  logic [3:0]            mem_wmask_d;

  logic                  idle;
  logic [2:0]            req_size;
  logic                  req_misaligned, req_cross, req_bad;
  logic [2:0]            al_op;
  logic [1:0]            al_off;
  logic [DATA_WIDTH-1:0] al_wdata, st_data, ld_merged, ld_result;
  logic [3:0]            st_mask;

  assign idle      = (state == IDLE);
  assign req_ready = idle;

  // While idle the aligner looks at the incoming request; afterwards at the latched one.
  assign al_op    = idle ? req_op : op_q;
  assign al_off   = idle ? req_addr[1:0] : off_q;
  assign al_wdata = idle ? req_wdata : wdata_q;

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .op        (al_op),
    .off       (al_off),
    .st_beat1  (!idle),
    .st_wdata  (al_wdata),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .ld_beat1  (state == WAIT1),
    .ld_rdata  (mem_rdata),
    .ld_beat0  (beat0_q),
    .ld_merged (ld_merged),
    .ld_result (ld_result)
  );

  always_comb begin
    req_size       = op_size(req_op);
    req_misaligned = ((req_size == 3'd2) & req_addr[0]) | ((req_size == 3'd4) & (|req_addr[1:0]));
    req_cross      = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_bad = op_illegal(req_we, req_op);
`else
    req_bad = op_illegal(req_we, req_op) | req_misaligned;
`endif
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    we_d        = we_q;
    op_d        = op_q;
    off_d       = off_q;
    cross_d     = cross_q;
    wdata_d     = wdata_q;
    beat0_d     = beat0_q;
    mem_valid_d = mem_valid;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          off_d   = req_addr[1:0];
          cross_d = req_cross;
          wdata_d = req_wdata;
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = req_we ? st_data : '0;
            mem_wmask_d = req_we ? st_mask : 4'b0000;
          end
        end
      end
      REQ0: begin
        if (mem_ready) begin
          if (!we_q) begin
            state_d     = WAIT0;
            mem_valid_d = 1'b0;
          end else if (cross_q) begin
            state_d     = REQ1;
            mem_addr_d  = mem_addr + ADDR_WIDTH'(4);
            mem_wdata_d = st_data;
            mem_wmask_d = st_mask;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          beat0_d = ld_merged;
          if (cross_q) begin
            state_d     = REQ1;
            mem_valid_d = 1'b1;
            mem_addr_d  = mem_addr + ADDR_WIDTH'(4);
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_result;
          end
        end
      end
      REQ1: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (we_q) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT1;
          end
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      op_q      <= 3'b000;
      off_q     <= 2'b00;
      cross_q   <= 1'b0;
      wdata_q   <= '0;
      beat0_q   <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      we_q      <= we_d;
      op_q      <= op_d;
      off_q     <= off_d;
      cross_q   <= cross_d;
      wdata_q   <= wdata_d;
      beat0_q   <= beat0_d;
      mem_valid <= mem_valid_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wmask <= mem_wmask_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Load/store access sequencer between the MEM pipeline stage and the single-port data memory. It accepts one load or store per handshake and drives word-aligned memory requests with byte lane masks. It merges the returned read data, then sign- or zero-extends it per funct3. When compiled in, accesses that cross a word boundary are split into two memory beats.

## Interface
Parameters:
- DATA_WIDTH, 32, data and memory word width (fixed 4 byte lanes)
- ADDR_WIDTH, 32, byte address width

Ports. One clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  pipeline access request
- req_ready  out  1  sequencer idle, request accepted when both high
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid: illegal op or rejected misalignment
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits 0
- mem_wdata  out  DATA_WIDTH  lane-positioned store data
- mem_wmask  out  4  byte enables; 0000 on reads
- mem_rvalid  in  1  read data valid, one per accepted read
- mem_rdata  in  DATA_WIDTH  read word

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1.
- req_ready = (state == IDLE).
- On accept, latch we, op, addr and wdata. Then compute size (1/2/4) and offset (off = addr[1:0]).
- Misaligned means addr is not a multiple of size. Crossing means off + size > 4.
- Illegal op (load 011/110/111; store any op other than 000/001/010): no memory access. rsp_valid=1, rsp_err=1 the next cycle; stay IDLE.
- Otherwise go to REQ0:
  - mem_addr = {addr[hi:2], 2'b00}
  - mem_wmask = (base << off)[3:0], where base is 0001/0011/1111
  - mem_wdata = wdata << 8*off
- In REQ0, hold mem_valid and all mem_* signals stable until mem_ready.
  - Store, not crossing: go to IDLE with rsp_valid.
  - Load: go to WAIT0.
  - Store, crossing: go to REQ1.
- In WAIT0, on mem_rvalid, capture beat0 = mem_rdata >> 8*off. Then go to IDLE with rsp_valid, or to REQ1 if crossing.
- In REQ1:
  - mem_addr = beat-0 address + 4
  - mem_wmask = base >> (4 - off)
  - mem_wdata = wdata >> 8*(4 - off)
  - After the handshake: load goes to WAIT1, store goes to IDLE with rsp_valid.
- In WAIT1, on mem_rvalid, merge (mem_rdata << 8*(4 - off)) into beat0, then go to IDLE with rsp_valid.
- Final extension on the merged word: b = sign-extend bits [7:0]; h = sign-extend [15:0]; w = pass-through; bu/hu = zero-extend.
- mem_rvalid is ignored outside WAIT0/WAIT1.
- Reset values: all outputs 0 except req_ready = 1; state = IDLE.
- Reset mid-access: return to IDLE immediately. A late mem_rvalid is ignored and no rsp_valid is produced.

## Timing
- rsp_valid, rsp_rdata, rsp_err and all mem_* outputs are registered.
- Accept at cycle T:
  - mem_valid first high at T+1.
  - Aligned store with mem_ready=1: rsp_valid at T+2.
  - Aligned load with rvalid one cycle after the handshake: rsp_valid at T+3.
- Each split adds one handshake plus, for loads, one read wait.
- rsp_valid is high in the same cycle req_ready returns high, so back-to-back accept is allowed.
- Error response at T+1.
- rsp_rdata holds its value between responses.
- Only one memory transaction is ever outstanding.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined:
  - Misaligned, non-crossing accesses use a single shifted beat.
  - Crossing accesses use two beats.
  - rsp_err is set only for illegal ops.
- Not defined:
  - Any misaligned access is rejected: rsp_err=1 at T+1, no mem_valid.
  - REQ1/WAIT1 are unreachable and may be omitted.

## Structure
- Package lsu_pkg:
  - funct3 op constants
  - state enum
  - size-from-op function
  - base-mask constants
- Sub-module lsu_lane_align (combinational):
  - store data shift and mask generation per beat
  - load merge and sign/zero extension
- The FSM and registers stay in lsu_seq.

## Test plan
- Aligned lw 0x100, mem_rdata 0xDEADBEEF, mem_ready=1: mem_addr 0x100, mask 0000, rsp_rdata 0xDEADBEEF at T+3.
- lb 0x103 with mem_rdata 0x80112233 -> 0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh 0x102, wdata 0x0000ABCD -> mem_addr 0x100, mem_wdata 0xABCD0000, mask 1100, rsp_valid at T+2.
- Macro on:
  - lw 0x101, beats 0x44332211 @0x100 and 0x88776655 @0x104 -> rsp_rdata 0x55443322.
  - sw 0x103, wdata 0xAABBCCDD -> beat0 {0x100, mask 1000, 0xDD000000}, beat1 {0x104, mask 0111, 0x00AABBCC}.
- Macro off: lw 0x101 -> rsp_err=1 at T+1, mem_valid never asserted. Illegal op 011 -> rsp_err=1 in both builds.
- mem_ready low for 3 cycles: mem_* stable throughout. Assert rst_n=0 in WAIT0: IDLE next, later mem_rvalid ignored, no rsp_valid.
